// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master state codes, transfer direction and arbiter FSM states.
package i2c_pkg;

  localparam logic [2:0] MstIdle       = 3'd0;
  localparam logic [2:0] MstAddressing = 3'd1;
  localparam logic [2:0] MstWaiting    = 3'd2;
  localparam logic [2:0] MstReading    = 3'd3;
  localparam logic [2:0] MstWriting    = 3'd4;
  localparam logic [2:0] MstDone       = 3'd5;

  localparam logic RwRead  = 1'b1;
  localparam logic RwWrite = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StRun,
    StComplete
  } arb_state_e;

endpackage

// File: rtl/i2c_rr_pick.sv
// Round-robin selector: first active request searching upward from (last+1) mod NREQ.
module i2c_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] last,
  output logic [NREQ-1:0] pick,
  output logic [IdxW-1:0] index
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    pick  = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IdxW'((32'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        pick[cand]  = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between NREQ requesters; all outputs registered.
// Define I2C_ARB_TIMEOUT_EN to add a RUN watchdog that ends a stuck transaction with err.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              err,
  output logic              busy,
  output logic              m_rst,
  output logic              m_rw,
  output logic [7:0]        m_data_in,
  input  logic [7:0]        m_data_out,
  input  logic [2:0]        m_state
);

  localparam int unsigned IdxW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES == 0) begin : gen_param_check
    $error("i2c_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES nonzero");
  end

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            m_rst_q, m_rst_d;
  logic            m_rw_q, m_rw_d;
  logic [7:0]      m_data_q, m_data_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] win_q, win_d;

  logic [NREQ-1:0] pick;
  logic [IdxW-1:0] pick_idx;
  logic            pick_rw;
  logic [7:0]      pick_wdata;
  logic            txn_end;
  logic            timed_out;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  i2c_rr_pick #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .pick  (pick),
    .index (pick_idx)
  );

  // One-hot mux of the winner's direction and write byte.
  always_comb begin
    pick_rw    = 1'b0;
    pick_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_rw    = req_rw[i];
        pick_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    busy_d    = busy_q;
    rdata_d   = rdata_q;
    m_rst_d   = m_rst_q;
    m_rw_d    = m_rw_q;
    m_data_d  = m_data_q;
    last_d    = last_q;
    win_d     = win_q;
    txn_end   = 1'b0;
    timed_out = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif

    unique case (state_q)
      // COMPLETE already carries the updated last, so it can arbitrate directly.
      StIdle, StComplete: begin
        m_rst_d = 1'b1;
        state_d = StIdle;
        if (|req) begin
          state_d  = StLaunch;
          gnt_d    = pick;
          busy_d   = 1'b1;
          win_d    = pick_idx;
          m_rw_d   = pick_rw;
          m_data_d = pick_wdata;
        end
      end
      StLaunch: begin
        state_d = StRun;
        m_rst_d = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StRun: begin
        if (m_state == MstDone) begin
          txn_end = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
          txn_end   = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    if (txn_end) begin
      state_d = StComplete;
      done_d  = gnt_q;
      gnt_d   = '0;
      busy_d  = 1'b0;
      m_rst_d = 1'b1;
      last_d  = win_q;
      if (!timed_out && m_rw_q == RwRead) begin
        rdata_d = m_data_out;
      end
`ifdef I2C_ARB_TIMEOUT_EN
      err_d = timed_out;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      rdata_q  <= 8'h00;
      m_rst_q  <= 1'b1;
      m_rw_q   <= 1'b1;
      m_data_q <= 8'h00;
      last_q   <= IdxW'(NREQ - 1);
      win_q    <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      rdata_q  <= rdata_d;
      m_rst_q  <= m_rst_d;
      m_rw_q   <= m_rw_d;
      m_data_q <= m_data_d;
      last_q   <= last_d;
      win_q    <= win_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign rdata     = rdata_q;
  assign m_rst     = m_rst_q;
  assign m_rw      = m_rw_q;
  assign m_data_in = m_data_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023: watchdog limit in clk cycles (used only with I2C_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port req, input, NREQ: per-requester transaction request; held high until that requester's done.
REQ-006 SHALL have port req_rw, input, NREQ: per-requester direction; 1=read, 0=write.
REQ-007 SHALL have port req_wdata, input, 8*NREQ: per-requester write byte; requester i uses bits [8i+7:8i].
REQ-008 SHALL have port gnt, output, NREQ: one-hot grant, high for the whole transaction.
REQ-009 SHALL have port done, output, NREQ: one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port rdata, output, 8: byte returned by the last completed read.
REQ-011 SHALL have port err, output, 1: one-cycle pulse coincident with done when the transaction timed out.
REQ-012 SHALL have port busy, output, 1: high from grant through completion.
REQ-013 SHALL have port m_rst, output, 1: active-high reset to the I2C master; deassertion starts a transaction.
REQ-014 SHALL have port m_rw, output, 1: direction to the master.
REQ-015 SHALL have port m_data_in, output, 8: write byte to the master.
REQ-016 SHALL have port m_data_out, input, 8: read byte from the master.
REQ-017 SHALL have port m_state, input, 3: master state code; 3'd5 = DONE.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, RUN and COMPLETE; all outputs SHALL be registered.
REQ-019 IDLE: m_rst=1; when req!=0, the arbiter SHALL select the winner round-robin, starting the search at (last+1) mod NREQ, latch its req_rw/req_wdata into m_rw/m_data_in, assert gnt/busy next cycle, and go to LAUNCH.
REQ-020 LAUNCH: hold m_rst=1 with m_rw/m_data_in stable for exactly 1 cycle, then go to RUN.
REQ-021 RUN: m_rst=0; m_rw/m_data_in SHALL remain constant; on m_state==3'd5 the arbiter SHALL go to COMPLETE.
REQ-022 Latency: req sampled in IDLE at cycle N -> gnt at N+1, m_rst low at N+2; DONE sampled at cycle K -> done/gnt-low/m_rst-high at K+1.
REQ-023 COMPLETE: pulse done[winner] for 1 cycle, clear gnt and busy, set last=winner, and return to IDLE; the earliest next grant SHALL be at K+2.
REQ-024 rdata SHALL load m_data_out only on completion of a successful read; it SHALL hold its value on writes and timeouts.
REQ-025 Deassertion of req by the granted requester mid-transaction SHALL be ignored; the transaction SHALL complete and done SHALL still pulse.
REQ-026 Requests arriving while busy SHALL wait; none SHALL be lost or reordered past the round-robin rule.
REQ-027 With a single requester continuously active, it SHALL be re-granted every transaction.
REQ-028 m_state values other than 3'd5 SHALL NOT affect sequencing.

Reset
REQ-029 rst=0 at any edge, including mid-transaction, SHALL force the following next cycle: state IDLE, gnt=0, done=0, err=0, busy=0, rdata=8'h00, m_rst=1, m_rw=1, m_data_in=8'h00, last=NREQ-1 (req[0] highest priority), timeout counter 0.

Configuration
REQ-030 With I2C_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to RUN and increment each RUN cycle.
REQ-031 With I2C_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES without DONE, the arbiter SHALL enter COMPLETE, pulse done and err together, and leave rdata unchanged.
REQ-032 Without I2C_ARB_TIMEOUT_EN, the counter SHALL be absent, err SHALL be tied 0, and RUN SHALL wait indefinitely for DONE.

Structure
REQ-033 Shared package i2c_pkg SHALL hold the master state codes (IDLE=0, ADDRESSING=1, WAITING=2, READING=3, WRITING=4, DONE=5), the READ=1/WRITE=0 constants and the arbiter state enum.
REQ-034 Round-robin selection SHALL be a sub-module i2c_rr_pick (inputs: req, last; outputs: one-hot pick, index).

Verification
REQ-035 Scenario: NREQ=4, only req[2]=1 (read), model returns 8'hF6, DONE after 40 cycles -> gnt=4'b0100 at N+1, m_rst low at N+2, done[2] and rdata=8'hF6 one cycle after DONE.
REQ-036 Scenario: req=4'b1111 held through several transactions after reset -> grant order 0,1,2,3,0, and each done pulse occurs exactly once.
REQ-037 Scenario: write from req[1] with wdata 8'hA5 -> m_rw=0 and m_data_in=8'hA5 stable throughout RUN; rdata keeps its previous value.
REQ-038 Scenario: rst pulled low mid-RUN -> next cycle m_rst=1, gnt=0, busy=0, with no done pulse; after release, req[0] wins over req[3].
REQ-039 Scenario: with I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, m_state stuck at 2 -> done and err pulse together 17 cycles after RUN entry; without the macro, err stays 0 and busy stays high.
REQ-040 Scenario: req[3] dropped mid-RUN -> the transaction completes and done[3] still pulses.
